dma_bus_arbiter: RTL

- Sits directly downstream of the ZX-Uno DMA engine, between it, the T80 CPU core and the shared memory/I/O bus.
- Converts the DMA's busrq_n into a CPU BUSRQ/BUSAK handshake.
- Inserts guard (dead) cycles with all strobes deasserted on every ownership change.
- Multiplexes address, write data and MREQ/IORQ/RD/WR from the current owner onto the shared bus, and returns busak_n to the DMA only once the bus is clean.

---
 rtl/dma_bus_pkg.sv | 47 ++++
 rtl/dma_bus_arbiter_if.sv | 48 ++++
 rtl/bus_guard_counter.sv | 34 +++
 rtl/dma_bus_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dma_bus_pkg.sv
// rtl/dma_bus_pkg.sv - shared state encoding, strobe ordering and bus types for the DMA bus arbiter
package dma_bus_pkg;

    localparam int ADDR_W               = 16;
    localparam int DATA_W               = 8;
    localparam int DEFAULT_GUARD_CYCLES = 2;
    localparam int GUARD_CNT_W          = 4;

    localparam logic [2:0] ST_CPU_OWNS  = 3'd0;
    localparam logic [2:0] ST_REQ_WAIT  = 3'd1;
    localparam logic [2:0] ST_GUARD_IN  = 3'd2;
    localparam logic [2:0] ST_DMA_OWNS  = 3'd3;
    localparam logic [2:0] ST_GUARD_OUT = 3'd4;
    localparam logic [2:0] ST_REL_WAIT  = 3'd5;

    typedef enum logic [2:0] {
        S_CPU_OWNS  = ST_CPU_OWNS,
        S_REQ_WAIT  = ST_REQ_WAIT,
        S_GUARD_IN  = ST_GUARD_IN,
        S_DMA_OWNS  = ST_DMA_OWNS,
        S_GUARD_OUT = ST_GUARD_OUT,
        S_REL_WAIT  = ST_REL_WAIT
    } arb_state_t;

    // Strobe bundle bit positions, packed as {mreq, iorq, rd, wr}
    localparam int STB_MREQ = 3;
    localparam int STB_IORQ = 2;
    localparam int STB_RD   = 1;
    localparam int STB_WR   = 0;

    localparam logic [3:0] STB_IDLE = 4'b1111;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        stb;
    } bus_drive_t;

    // Dead cycle: keep address/data stable, deassert every strobe
    function automatic bus_drive_t quiesce(input bus_drive_t cur);
        bus_drive_t r;
        r     = cur;
        r.stb = STB_IDLE;
        return r;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// rtl/dma_bus_arbiter_if.sv - DMA, CPU and shared-bus signal bundle for the arbiter
interface dma_bus_arbiter_if;
    import dma_bus_pkg::*;

    logic              dma_busrq_n;
    logic              dma_busak_n;
    logic [ADDR_W-1:0] dma_a;
    logic [DATA_W-1:0] dma_dout;
    logic              dma_mreq_n;
    logic              dma_iorq_n;
    logic              dma_rd_n;
    logic              dma_wr_n;
    logic [DATA_W-1:0] dma_din;

    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_mreq_n;
    logic              cpu_iorq_n;
    logic              cpu_rd_n;
    logic              cpu_wr_n;
    logic              cpu_busrq_n;
    logic              cpu_busak_n;

    logic [ADDR_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_mreq_n;
    logic              bus_iorq_n;
    logic              bus_rd_n;
    logic              bus_wr_n;
    logic [DATA_W-1:0] bus_din;

    modport slave (
        input  dma_busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        input  cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_busak_n,
        input  bus_din,
        output dma_busak_n, dma_din, cpu_busrq_n,
        output bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n
    );

    modport master (
        output dma_busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
        output cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_busak_n,
        output bus_din,
        input  dma_busak_n, dma_din, cpu_busrq_n,
        input  bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n
    );

endinterface

// File: rtl/bus_guard_counter.sv
// rtl/bus_guard_counter.sv - loadable down-counter timing the dead cycles around an ownership switch
module bus_guard_counter
    import dma_bus_pkg::*;
#(
    parameter int W = GUARD_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_last
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);
    // o_last marks the final guard cycle, letting the FSM switch owner on the edge that reaches zero
    assign o_last = (r_count == ONE);

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - hands the shared Z80 bus between the T80 and the DMA with guarded switchovers
module dma_bus_arbiter
    import dma_bus_pkg::*;
#(
    parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
    parameter int HOLD_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dma_bus_arbiter_if.slave      bif,
    output logic                  dma_owner,
    output logic [HOLD_CNT_W-1:0] hold_cycles
);

    localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES);
    localparam logic [HOLD_CNT_W-1:0]  HOLD_MAX   = '1;
    localparam logic [HOLD_CNT_W-1:0]  HOLD_ONE   = {{(HOLD_CNT_W-1){1'b0}}, 1'b1};

    arb_state_t              r_state;
    logic                    r_cpu_busrq_n;
    logic                    r_dma_busak_n;
    logic                    r_dma_owner;
    logic [HOLD_CNT_W-1:0]   r_hold;
    bus_drive_t              r_bus;

    bus_drive_t              w_cpu_drive;
    bus_drive_t              w_dma_drive;
    logic                    w_cnt_load;
    logic                    w_cnt_dec;
    logic                    w_cnt_zero;
    logic                    w_cnt_last;
    logic                    w_guard_done;

    assign w_cpu_drive.addr = bif.cpu_a;
    assign w_cpu_drive.data = bif.cpu_dout;
    assign w_cpu_drive.stb  = {bif.cpu_mreq_n, bif.cpu_iorq_n, bif.cpu_rd_n, bif.cpu_wr_n};

    assign w_dma_drive.addr = bif.dma_a;
    assign w_dma_drive.data = bif.dma_dout;
    assign w_dma_drive.stb  = {bif.dma_mreq_n, bif.dma_iorq_n, bif.dma_rd_n, bif.dma_wr_n};

    // The counter is armed on the same edge that enters either guard state
    assign w_cnt_load = ((r_state == S_REQ_WAIT) && !bif.dma_busrq_n && !bif.cpu_busak_n) ||
                        ((r_state == S_DMA_OWNS) && bif.dma_busrq_n);
    assign w_cnt_dec  = (r_state == S_GUARD_IN) || (r_state == S_GUARD_OUT);
    assign w_guard_done = w_cnt_last || w_cnt_zero;

    bus_guard_counter #(
        .W (GUARD_CNT_W)
    ) u_guard_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (GUARD_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_CPU_OWNS;
            r_cpu_busrq_n <= 1'b1;
            r_dma_busak_n <= 1'b1;
            r_dma_owner   <= 1'b0;
            r_hold        <= '0;
            r_bus         <= '{addr: '0, data: '0, stb: STB_IDLE};
        end else begin
            case (r_state)
                S_CPU_OWNS: begin
                    r_bus <= w_cpu_drive;
                    if (!bif.dma_busrq_n) begin
                        r_cpu_busrq_n <= 1'b0;
                        r_state       <= S_REQ_WAIT;
                    end
                end
                S_REQ_WAIT: begin
                    // A withdrawn request beats a grant seen on the same edge
                    if (bif.dma_busrq_n) begin
                        r_cpu_busrq_n <= 1'b1;
                        r_bus         <= quiesce(r_bus);
                        r_state       <= S_REL_WAIT;
                    end else if (!bif.cpu_busak_n) begin
                        r_bus   <= quiesce(r_bus);
                        r_state <= S_GUARD_IN;
                    end else begin
                        r_bus <= w_cpu_drive;
                    end
                end
                S_GUARD_IN: begin
                    if (w_guard_done) begin
                        r_dma_busak_n <= 1'b0;
                        r_dma_owner   <= 1'b1;
                        r_hold        <= '0;
                        r_bus         <= w_dma_drive;
                        r_state       <= S_DMA_OWNS;
                    end else begin
                        r_bus <= quiesce(r_bus);
                    end
                end
                S_DMA_OWNS: begin
                    if (r_hold != HOLD_MAX) begin
                        r_hold <= r_hold + HOLD_ONE;
                    end
                    if (bif.dma_busrq_n) begin
                        r_dma_busak_n <= 1'b1;
                        r_dma_owner   <= 1'b0;
                        r_bus         <= quiesce(r_bus);
                        r_state       <= S_GUARD_OUT;
                    end else begin
                        r_bus <= w_dma_drive;
                    end
                end
                S_GUARD_OUT: begin
                    r_bus <= quiesce(r_bus);
                    if (w_guard_done) begin
                        r_cpu_busrq_n <= 1'b1;
                        r_state       <= S_REL_WAIT;
                    end
                end
                S_REL_WAIT: begin
                    // Always passes through CPU_OWNS, so the CPU gets a cycle before any new burst
                    if (bif.cpu_busak_n) begin
                        r_bus   <= w_cpu_drive;
                        r_state <= S_CPU_OWNS;
                    end else begin
                        r_bus <= quiesce(r_bus);
                    end
                end
                default: begin
                    r_cpu_busrq_n <= 1'b1;
                    r_dma_busak_n <= 1'b1;
                    r_dma_owner   <= 1'b0;
                    r_bus         <= quiesce(r_bus);
                    r_state       <= S_CPU_OWNS;
                end
            endcase
        end
    end

    assign bif.bus_a       = r_bus.addr;
    assign bif.bus_dout    = r_bus.data;
    assign bif.bus_mreq_n  = r_bus.stb[STB_MREQ];
    assign bif.bus_iorq_n  = r_bus.stb[STB_IORQ];
    assign bif.bus_rd_n    = r_bus.stb[STB_RD];
    assign bif.bus_wr_n    = r_bus.stb[STB_WR];

    assign bif.cpu_busrq_n = r_cpu_busrq_n;
    assign bif.dma_busak_n = r_dma_busak_n;
    assign bif.dma_din     = bif.bus_din;

    assign dma_owner   = r_dma_owner;
    assign hold_cycles = r_hold;

endmodule
